// File: rtl/hw5_risc_if_if.sv
// Instruction-memory request/acknowledge bus between the IF stage and imem.
// master = fetch stage (drives request), slave = memory (drives ack/data).
interface hw5_risc_if_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/hw5_risc_if.sv
// HW5 RISC instruction-fetch stage: PC, req/ack fetch FSM, IF/DOF pipeline register.
// Optional `IF_PERF_CNT_EN adds saturating fetch/bubble counters.
module hw5_risc_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [31:0]        br_target,
  hw5_risc_if_if.master      imem,
  output logic [31:0]        IF_DOF_IR,
  output logic [31:0]        IF_DOF_PC
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        if_fetch_cnt,
  output logic [31:0]        if_bubble_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] req_addr_reg, req_addr_next;
  logic [31:0] hold_ir_reg, hold_ir_next;
  logic [31:0] hold_pc_reg, hold_pc_next;
  logic [31:0] ir_reg, ir_next;
  logic [31:0] ir_pc_reg, ir_pc_next;
  logic [31:0] addr_inc;

  assign addr_inc       = req_addr_reg + 32'd1;
  assign imem.imem_addr = req_addr_reg;
  assign IF_DOF_IR      = ir_reg;
  assign IF_DOF_PC      = ir_pc_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  state_next = REQ;
      REQ: begin
        if (br_taken)                        state_next = imem.imem_ack ? REQ : DRAIN;
        else if (imem.imem_ack && stall)     state_next = HOLD;
      end
      HOLD:  if (br_taken || !stall) state_next = REQ;
      DRAIN: if (imem.imem_ack)      state_next = REQ;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    imem.imem_req = (state_reg == REQ) || (state_reg == DRAIN);
    pc_next       = pc_reg;
    req_addr_next = req_addr_reg;
    hold_ir_next  = hold_ir_reg;
    hold_pc_next  = hold_pc_reg;
    ir_next       = ir_reg;
    ir_pc_next    = ir_pc_reg;
    case (state_reg)
      IDLE: req_addr_next = pc_reg;
      REQ: begin
        if (imem.imem_ack && !stall) begin
          ir_next       = imem.imem_rdata;
          ir_pc_next    = addr_inc;
          pc_next       = addr_inc;
          req_addr_next = addr_inc;
        end else if (imem.imem_ack) begin
          hold_ir_next = imem.imem_rdata;
          hold_pc_next = addr_inc;
          pc_next      = addr_inc;
        end else if (!stall) begin
          ir_next    = 32'h0;
          ir_pc_next = 32'h0;
        end
      end
      HOLD: begin
        if (!stall) begin
          ir_next       = hold_ir_reg;
          ir_pc_next    = hold_pc_reg;
          req_addr_next = pc_reg;
        end
      end
      DRAIN: begin
        // The stale word is dropped; only the address moves on.
        if (imem.imem_ack) req_addr_next = pc_reg;
        if (!stall) begin
          ir_next    = 32'h0;
          ir_pc_next = 32'h0;
        end
      end
      default: ;
    endcase
    // A redirect beats stall and everything else in the same cycle.
    if (br_taken) begin
      pc_next      = br_target;
      hold_ir_next = 32'h0;
      hold_pc_next = 32'h0;
      ir_next      = 32'h0;
      ir_pc_next   = 32'h0;
      if (!imem.imem_req || imem.imem_ack) req_addr_next = br_target;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg       <= RESET_PC;
      req_addr_reg <= RESET_PC;
      hold_ir_reg  <= 32'h0;
      hold_pc_reg  <= 32'h0;
      ir_reg       <= 32'h0;
      ir_pc_reg    <= 32'h0;
    end else begin
      pc_reg       <= pc_next;
      req_addr_reg <= req_addr_next;
      hold_ir_reg  <= hold_ir_next;
      hold_pc_reg  <= hold_pc_next;
      ir_reg       <= ir_next;
      ir_pc_reg    <= ir_pc_next;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic        fetch_load, bubble_load;
  logic [31:0] fetch_cnt_reg, bubble_cnt_reg;

  assign fetch_load  = !br_taken && !stall &&
                       ((state_reg == REQ && imem.imem_ack) || state_reg == HOLD);
  assign bubble_load = br_taken || (!stall &&
                       ((state_reg == REQ && !imem.imem_ack) || state_reg == DRAIN));
  assign if_fetch_cnt  = fetch_cnt_reg;
  assign if_bubble_cnt = bubble_cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt_reg  <= 32'h0;
      bubble_cnt_reg <= 32'h0;
    end else begin
      if (fetch_load && fetch_cnt_reg != 32'hFFFF_FFFF)
        fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
      if (bubble_load && bubble_cnt_reg != 32'hFFFF_FFFF)
        bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hw5_risc_if.sv
// Self-checking bench for hw5_risc_if: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based behavioural fetch model.
module tb_hw5_risc_if;
  localparam logic [31:0] RPC = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, br_taken;
  logic [31:0] br_target;
  logic [31:0] IF_DOF_IR, IF_DOF_PC;
  logic [31:0] key;
`ifdef IF_PERF_CNT_EN
  logic [31:0] if_fetch_cnt, if_bubble_cnt;
`endif

  hw5_risc_if_if imem_bus();

  hw5_risc_if #(.RESET_PC(RPC)) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_target (br_target),
    .imem      (imem_bus),
    .IF_DOF_IR (IF_DOF_IR),
    .IF_DOF_PC (IF_DOF_PC)
`ifdef IF_PERF_CNT_EN
    ,
    .if_fetch_cnt  (if_fetch_cnt),
    .if_bubble_cnt (if_bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory content: word = address xor key (key 0 gives word == address).
  assign imem_bus.imem_rdata = imem_bus.imem_addr ^ key;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: what the fetch stage has outstanding, what it owes DOF.
  logic [31:0] m_pc, m_req_addr, m_ir, m_irpc, m_fetch, m_bubble;
  bit          m_started, m_req_on, m_discard;
  logic [63:0] held[$];

  task automatic model_reset();
    m_pc = RPC; m_req_addr = RPC; m_ir = 0; m_irpc = 0;
    m_fetch = 0; m_bubble = 0;
    m_started = 0; m_req_on = 0; m_discard = 0;
    held.delete();
  endtask

  task automatic give_bubble();
    m_ir = 0; m_irpc = 0;
    if (m_bubble != 32'hFFFF_FFFF) m_bubble++;
  endtask

  task automatic model_step(input bit s, input bit b, input logic [31:0] t, input bit a);
    logic [31:0] word;
    word = m_req_addr ^ key;
    if (!m_started) begin
      m_started = 1; m_req_on = 1;
      if (b) begin m_pc = t; m_req_addr = t; give_bubble(); end
      else m_req_addr = m_pc;
    end else if (b) begin
      m_pc = t; held.delete(); give_bubble();
      if (m_req_on && !a) m_discard = 1;
      else begin m_req_on = 1; m_req_addr = t; m_discard = 0; end
    end else if (held.size() != 0) begin
      if (!s) begin
        {m_ir, m_irpc} = held.pop_front();
        if (m_fetch != 32'hFFFF_FFFF) m_fetch++;
        m_req_on = 1; m_req_addr = m_pc;
      end
    end else if (m_discard) begin
      if (a) begin m_discard = 0; m_req_addr = m_pc; end
      if (!s) give_bubble();
    end else if (a) begin
      if (s) begin
        held.push_back({word, m_req_addr + 32'd1});
        m_req_on = 0; m_pc = m_req_addr + 32'd1;
      end else begin
        m_ir = word; m_irpc = m_req_addr + 32'd1;
        if (m_fetch != 32'hFFFF_FFFF) m_fetch++;
        m_req_addr = m_req_addr + 32'd1; m_pc = m_req_addr;
      end
    end else if (!s) give_bubble();
  endtask

  task automatic compare_all();
    check_val("imem_req", {31'b0, imem_bus.imem_req}, {31'b0, m_req_on});
    if (m_req_on) check_val("imem_addr", imem_bus.imem_addr, m_req_addr);
    check_val("ir", IF_DOF_IR, m_ir);
    check_val("ir_pc", IF_DOF_PC, m_irpc);
`ifdef IF_PERF_CNT_EN
    check_val("fetch_cnt", if_fetch_cnt, m_fetch);
    check_val("bubble_cnt", if_bubble_cnt, m_bubble);
`endif
  endtask

  // One clock: apply inputs, step both DUT and model, compare, log.
  task automatic cyc(input bit s, input bit b, input logic [31:0] t, input bit a);
    stall = s; br_taken = b; br_target = t; imem_bus.imem_ack = a;
    @(posedge clk);
    #1;
    model_step(s, b, t, a);
    compare_all();
    $display("t=%0t st=%0b br=%0b tgt=%h ack=%0b req=%0b addr=%h ir=%h pc=%h",
             $time, s, b, t, a, imem_bus.imem_req, imem_bus.imem_addr, IF_DOF_IR, IF_DOF_PC);
  endtask

  initial begin
    reset = 1'b0; stall = 0; br_taken = 0; br_target = 0;
    imem_bus.imem_ack = 1'b1; key = 0;
    model_reset();
    #12;
    check_val("rst_req", {31'b0, imem_bus.imem_req}, 32'd0);
    check_val("rst_addr", imem_bus.imem_addr, RPC);
    check_val("rst_ir", IF_DOF_IR, 32'd0);
    check_val("rst_pc", IF_DOF_PC, 32'd0);
    @(posedge clk); #1;
    check_val("rst_ack_ignored", IF_DOF_IR, 32'd0);
    reset = 1'b1;

    // Zero-wait fetch from RESET_PC
    cyc(0, 0, 0, 1);
    check_val("zw_first_req", imem_bus.imem_addr, 32'h10);
    cyc(0, 0, 0, 1); check_val("zw_ir0", IF_DOF_IR, 32'h10);
    cyc(0, 0, 0, 1); check_val("zw_ir1", IF_DOF_IR, 32'h11);
    cyc(0, 0, 0, 1); check_val("zw_ir2", IF_DOF_IR, 32'h12);
    check_val("zw_pc2", IF_DOF_PC, 32'h13);

    // Two wait states per fetch
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0); check_val("ws_bubble", IF_DOF_IR, 32'h0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 1); check_val("ws_ir", IF_DOF_IR, 32'h13 + i);
    end

    // Stall covering the ack of address 5
    cyc(0, 1, 32'h3, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1); check_val("st_pre", IF_DOF_IR, 32'h4);
    cyc(1, 0, 0, 1); check_val("st_frozen0", IF_DOF_IR, 32'h4);
    cyc(1, 0, 0, 0); check_val("st_noreq", {31'b0, imem_bus.imem_req}, 32'd0);
    cyc(1, 0, 0, 0); check_val("st_frozen2", IF_DOF_IR, 32'h4);
    cyc(0, 0, 0, 0); check_val("st_release", IF_DOF_IR, 32'h5);
    check_val("st_release_pc", IF_DOF_PC, 32'h6);

    // Redirect to 0x40 while the request for 7 waits
    cyc(0, 0, 0, 1); check_val("rd_pre", imem_bus.imem_addr, 32'h7);
    cyc(0, 1, 32'h40, 0); check_val("rd_hold_addr", imem_bus.imem_addr, 32'h7);
    cyc(0, 0, 0, 0); check_val("rd_drain_ir", IF_DOF_IR, 32'h0);
    cyc(0, 0, 0, 1); check_val("rd_newreq", imem_bus.imem_addr, 32'h40);
    check_val("rd_discard", IF_DOF_IR, 32'h0);
    cyc(0, 0, 0, 1); check_val("rd_target", IF_DOF_IR, 32'h40);

    // Redirect + stall from HOLD
    cyc(1, 0, 0, 1);
    cyc(1, 1, 32'h80, 0); check_val("hs_flush", IF_DOF_IR, 32'h0);
    cyc(0, 0, 0, 1); check_val("hs_target", IF_DOF_IR, 32'h80);

    // PC wrap
    cyc(0, 1, 32'hFFFF_FFFF, 1);
    cyc(0, 0, 0, 1); check_val("wrap_ir", IF_DOF_IR, 32'hFFFF_FFFF);
    check_val("wrap_pc", IF_DOF_PC, 32'h0);
    check_val("wrap_addr", imem_bus.imem_addr, 32'h0);

    // Random traffic
    key = $urandom;
    for (int i = 0; i < 400; i++) begin
      bit s, b, a;
      logic [31:0] t;
      s = ($urandom_range(0, 9) < 3);
      b = ($urandom_range(0, 99) < 8);
      a = ($urandom_range(0, 1) == 1);
      t = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 255));
      cyc(s, b, t, a);
    end

    // Asynchronous reset in the middle of a request
    key = 0;
    cyc(0, 1, 32'h20, 1);
    cyc(0, 0, 0, 0);
    check_val("ar_pre_req", {31'b0, imem_bus.imem_req}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check_val("ar_req", {31'b0, imem_bus.imem_req}, 32'd0);
    check_val("ar_ir", IF_DOF_IR, 32'd0);
    check_val("ar_pc", IF_DOF_PC, 32'd0);
    check_val("ar_addr", imem_bus.imem_addr, RPC);
`ifdef IF_PERF_CNT_EN
    check_val("ar_fcnt", if_fetch_cnt, 32'd0);
    check_val("ar_bcnt", if_bubble_cnt, 32'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1); check_val("ar_restart", IF_DOF_IR, 32'h10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
